// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flag and a registered read port.
module fifo_umbrales #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   alto, bajo;
  logic                  active, pop_ok, push_ok, ovf, udf;

  assign active  = (state == ACTIVE);
  assign pop_ok  = active && pop && (count != '0);
  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign push_ok = active && push && ((count < DEPTH_C) || pop_ok);
  assign ovf     = active && push && !push_ok;
  assign udf     = active && pop && (count == '0);

  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (state == IDLE && init) state_nxt = ACTIVE;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      alto <= DEPTH_C - (ADDR_WIDTH+1)'(1);
      bajo <= (ADDR_WIDTH+1)'(1);
    end else if (init) begin
      alto <= umbral_alto;
      bajo <= umbral_bajo;
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= data_in;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        data_out <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
      error <= (error && !(active && init)) || ovf || udf;
    end
  end

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == DEPTH_C);
  assign almost_full  = active && (count >= alto);
  assign almost_empty = active && (count <= bajo);
endmodule

// File: doc/fifo_umbrales.md
# fifo_umbrales

Parameterised synchronous FIFO with programmable almost-full / almost-empty thresholds, sticky error flag and registered read port. One instance sits on each of the four input lanes directly upstream of the lane arbiter; its `fifo_empty` and `almost_full` flags drive the arbiter's `FIFO_empty` and `Almost_full` vectors. The arbiter's `Pops` bit for that lane drives this block's `pop`. A second bank of instances uses the same block on the output side, where the arbiter's `Push` drives `push`.

## Interface
- `DATA_WIDTH`, 8, width of each stored word.
- `ADDR_WIDTH`, 3, pointer width. Depth `DEPTH = 2**ADDR_WIDTH` (8).
- `clk` input 1: single clock, all state on rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `init` input 1: loads thresholds; leaves IDLE.
- `umbral_alto` input ADDR_WIDTH+1: almost-full threshold, sampled when `init=1`.
- `umbral_bajo` input ADDR_WIDTH+1: almost-empty threshold, sampled when `init=1`.
- `push` input 1: write `data_in` this edge.
- `data_in` input DATA_WIDTH: write data.
- `pop` input 1: read one word this edge.
- `data_out` output DATA_WIDTH: registered read data.
- `valid_out` output 1: `data_out` holds a word popped at the last edge.
- `fifo_empty` output 1: `count == 0`.
- `fifo_full` output 1: `count == DEPTH`.
- `almost_full` output 1: `count >= umbral_alto` (ACTIVE only).
- `almost_empty` output 1: `count <= umbral_bajo` (ACTIVE only).
- `error` output 1: sticky overflow/underflow indicator.
- `count` output ADDR_WIDTH+1: current occupancy, 0..DEPTH.

## Operation
- **FSM states:** IDLE and ACTIVE.
- **Reset:** `reset_L=0` forces IDLE immediately, regardless of clock.
  - Pointers and `count` go to 0.
  - `data_out=0`, `valid_out=0`, `error=0`.
  - Thresholds reset to `umbral_alto=DEPTH-1`, `umbral_bajo=1`.
  - Memory contents are don't-care.
  - A reset in the middle of traffic discards all stored words.
- **IDLE:**
  - `push` and `pop` are ignored and do not set `error`.
  - `fifo_empty=1`, `almost_full=0`, `almost_empty=0`.
  - `init=1` at an edge latches both thresholds and moves to ACTIVE.
- **ACTIVE, `init=1`:**
  - Reloads both thresholds and clears `error`.
  - Stored data, pointers and `count` are preserved.
  - `push`/`pop` on the same edge are processed normally.
- **Push:**
  - If `count < DEPTH`, or a valid pop occurs on the same edge: write `mem[wr_ptr]=data_in` and increment `wr_ptr`.
  - Otherwise (`count == DEPTH` with no pop): drop the word and set `error`.
- **Pop:**
  - If `count > 0`: `data_out <= mem[rd_ptr]`, increment `rd_ptr`, `valid_out <= 1`.
  - Otherwise: no pointer change, `valid_out <= 0`, set `error`.
  - No write-through bypass. A pop on empty with a simultaneous push is still an underflow; the push is accepted.
- **No pop:** `valid_out <= 0`; `data_out` holds its last value.
- **Count update:**
  - Increments on an accepted push only.
  - Decrements on an accepted pop only.
  - Unchanged when both are accepted.
- **Pointers:** wrap modulo DEPTH (natural ADDR_WIDTH overflow).
- **Flags:** combinational from registered `count` and the threshold registers.
- **Error:** sticky until reset or `init` in ACTIVE.
- **Invalid thresholds:** `umbral_alto > DEPTH` means `almost_full` never asserts. This is legal and not checked.

## Timing
- Push accepted at edge N: the word is poppable at edge N+1, and appears on `data_out` after edge N+1. Minimum push-to-`data_out` latency is 2 edges.
- Pop at edge N: `data_out`/`valid_out` are valid from after edge N until edge N+1.
- Flags and `count` reflect edge-N activity immediately after edge N. The arbiter sees the new `fifo_empty`/`almost_full` at edge N+1.
- `init` takes effect at its edge. Flags use the new thresholds from that edge onward.
- `reset_L` deassertion is not synchronised here; it must be released away from a `clk` edge.

## Test plan
- **Reset/IDLE:** reset, then push=1 with `data_in=8'hAA` for 3 cycles without `init` -> `count=0`, `fifo_empty=1`, `error=0`, `valid_out=0`.
- **Fill and thresholds:** `init` with `umbral_alto=6`, `umbral_bajo=2`; push 8'h01..8'h08 -> `almost_empty=1` at counts 1-2 and 0 at count 3; `almost_full=1` from count 6; `fifo_full=1` at count 8.
- **Overflow, then full push+pop:**
  - At count 8, push 8'h09 alone -> `error=1`, `count=8`.
  - Then push 8'h0A with pop -> `data_out=8'h01`, `count=8`.
  - Drain the rest -> order 8'h02..8'h08, 8'h0A, with 8'h09 absent.
- **Underflow:** pop on empty with simultaneous push 8'h55 -> `valid_out=0`, `error=1`, `count=1`. The next pop returns 8'h55.
- **Wrap-around:** 20 alternating push/pop pairs of incrementing data -> each `data_out` equals the value pushed one edge earlier, `count` stays within 0..1, `error=0`.
- **Mid-operation reset and re-init:**
  - At count 5, pulse `reset_L` low between edges -> `count=0`, `data_out=0`, `error=0`, and the FSM is in IDLE.
  - `init` in ACTIVE with `error=1` -> `error` clears and data is preserved.
